// File: rtl/debug_host.sv
// Host-side debug link initiator: streams a ROM program to the target, starts it and collects the dump.
// One UART byte in flight at a time (next byte only after i_tx_done); response words pulse one cycle after their 4th byte.
module debug_host #(
  parameter int NB_DATA        = 32,
  parameter int N_BITS         = 8,
  parameter int NB_ADDR        = 8,
  parameter int N_REGS         = 32,
  parameter int N_MEM_WORDS    = 32,
  parameter int NB_INDEX       = 7,
  parameter int NB_TIMEOUT     = 24,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_STATE       = 10
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_step_mode,
  input  logic [NB_ADDR-1:0]  i_prog_len,
  output logic [NB_ADDR-1:0]  o_prog_addr,
  input  logic [NB_DATA-1:0]  i_prog_data,
  output logic [N_BITS-1:0]   o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_done,
  input  logic [N_BITS-1:0]   i_rx_data,
  input  logic                i_rx_done,
  output logic [NB_DATA-1:0]  o_resp_word,
  output logic [NB_INDEX-1:0] o_resp_index,
  output logic                o_resp_valid,
  output logic [N_BITS-1:0]   o_status,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [NB_STATE-1:0] o_state
);

  localparam int BYTES       = NB_DATA / N_BITS;
  localparam int BC_W        = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int FRAME_WORDS = 1 + N_REGS + N_MEM_WORDS;

  localparam logic [N_BITS-1:0] CMD_LOAD = N_BITS'(8'h01);
  localparam logic [N_BITS-1:0] CMD_RUN  = N_BITS'(8'h02);
  localparam logic [N_BITS-1:0] CMD_STEP = N_BITS'(8'h03);
  localparam logic [N_BITS-1:0] ST_RUN   = N_BITS'(8'h00);
  localparam logic [N_BITS-1:0] ST_HALT  = N_BITS'(8'hFF);

  typedef enum logic [NB_STATE-1:0] {
    IDLE       = NB_STATE'(1),
    SEND_LOAD  = NB_STATE'(2),
    SEND_LEN   = NB_STATE'(4),
    FETCH      = NB_STATE'(8),
    SEND_INSTR = NB_STATE'(16),
    SEND_EXEC  = NB_STATE'(32),
    RX_STATUS  = NB_STATE'(64),
    RX_WORD    = NB_STATE'(128),
    DONE       = NB_STATE'(256),
    ERROR      = NB_STATE'(512)
  } state_t;

  state_t                     state;
  logic                       tx_wait;
  logic                       fetch_ph;
  logic                       step_q;
  logic [NB_ADDR-1:0]         len_q;
  logic [NB_ADDR-1:0]         instr_cnt;
  logic [NB_DATA-1:0]         instr_sh;
  logic [NB_DATA-N_BITS-1:0]  word_sh;
  logic [BC_W-1:0]            byte_cnt;
  logic [NB_INDEX-1:0]        word_idx;
  logic [NB_TIMEOUT-1:0]      wd_cnt;

  logic [NB_ADDR-1:0]         instr_inc;
  logic [NB_DATA-1:0]         word_next;
  logic                       waiting;
  logic                       timeout;

  assign instr_inc = instr_cnt + 1'b1;
  assign word_next = {word_sh, i_rx_data};
  assign waiting   = tx_wait || (state == RX_STATUS) || (state == RX_WORD);
  assign timeout   = waiting && !i_tx_done && !i_rx_done &&
                     (wd_cnt == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));

  assign o_state = state;
  assign o_done  = (state == DONE);
  assign o_error = (state == ERROR);
  assign o_busy  = !((state == IDLE) || (state == DONE) || (state == ERROR));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      tx_wait      <= 1'b0;
      fetch_ph     <= 1'b0;
      step_q       <= 1'b0;
      len_q        <= '0;
      instr_cnt    <= '0;
      instr_sh     <= '0;
      word_sh      <= '0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      wd_cnt       <= '0;
      o_prog_addr  <= '0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_resp_word  <= '0;
      o_resp_index <= '0;
      o_resp_valid <= 1'b0;
      o_status     <= '0;
    end else begin
      o_tx_start   <= 1'b0;
      o_resp_valid <= 1'b0;

      // Any handshake event or non-waiting cycle restarts the watchdog, which also covers state changes.
      if (!waiting || i_tx_done || i_rx_done)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;

      if (timeout) begin
        state   <= ERROR;
        tx_wait <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (i_start) begin
              state       <= SEND_LOAD;
              step_q      <= i_step_mode;
              len_q       <= i_prog_len;
              instr_cnt   <= '0;
              word_idx    <= '0;
              byte_cnt    <= '0;
              tx_wait     <= 1'b0;
              fetch_ph    <= 1'b0;
              o_prog_addr <= '0;
            end
          end

          SEND_LOAD: begin
            if (!tx_wait) begin
              o_tx_start <= 1'b1;
              o_tx_data  <= CMD_LOAD;
              tx_wait    <= 1'b1;
            end else if (i_tx_done) begin
              tx_wait <= 1'b0;
              state   <= SEND_LEN;
            end
          end

          SEND_LEN: begin
            if (!tx_wait) begin
              o_tx_start <= 1'b1;
              o_tx_data  <= N_BITS'(len_q);
              tx_wait    <= 1'b1;
            end else if (i_tx_done) begin
              tx_wait <= 1'b0;
              if (len_q == '0) begin
                state <= SEND_EXEC;
              end else begin
                state       <= FETCH;
                fetch_ph    <= 1'b0;
                o_prog_addr <= instr_cnt;
              end
            end
          end

          // Address is registered on entry; the synchronous ROM answers one cycle later.
          FETCH: begin
            if (!fetch_ph) begin
              fetch_ph <= 1'b1;
            end else begin
              fetch_ph <= 1'b0;
              instr_sh <= i_prog_data;
              byte_cnt <= '0;
              state    <= SEND_INSTR;
            end
          end

          SEND_INSTR: begin
            if (!tx_wait) begin
              o_tx_start <= 1'b1;
              o_tx_data  <= instr_sh[NB_DATA-1 -: N_BITS];
              instr_sh   <= instr_sh << N_BITS;
              tx_wait    <= 1'b1;
            end else if (i_tx_done) begin
              tx_wait <= 1'b0;
              if (byte_cnt == BC_W'(BYTES - 1)) begin
                byte_cnt  <= '0;
                instr_cnt <= instr_inc;
                if (instr_inc == len_q) begin
                  state <= SEND_EXEC;
                end else begin
                  state       <= FETCH;
                  fetch_ph    <= 1'b0;
                  o_prog_addr <= instr_inc;
                end
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end

          SEND_EXEC: begin
            if (!tx_wait) begin
              o_tx_start <= 1'b1;
              o_tx_data  <= step_q ? CMD_STEP : CMD_RUN;
              tx_wait    <= 1'b1;
            end else if (i_tx_done) begin
              tx_wait  <= 1'b0;
              word_idx <= '0;
              byte_cnt <= '0;
              state    <= RX_STATUS;
            end
          end

          RX_STATUS: begin
            if (i_rx_done) begin
              o_status <= i_rx_data;
              if ((i_rx_data == ST_RUN) || (i_rx_data == ST_HALT))
                state <= RX_WORD;
              else
                state <= ERROR;
            end
          end

          RX_WORD: begin
            if (i_rx_done) begin
              word_sh <= word_next[NB_DATA-N_BITS-1:0];
              if (byte_cnt == BC_W'(BYTES - 1)) begin
                byte_cnt     <= '0;
                o_resp_word  <= word_next;
                o_resp_valid <= 1'b1;
                o_resp_index <= word_idx;
                word_idx     <= word_idx + 1'b1;
                if (word_idx == NB_INDEX'(FRAME_WORDS - 1)) begin
                  if (o_status == ST_HALT)
                    state <= DONE;
                  else if (step_q)
                    state <= SEND_EXEC;
                  else
                    state <= ERROR;
                end
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/debug_host.md
Name: debug_host

Overview:
- Host-side initiator for the pipeline debug link. It drives the same UART byte interface the on-chip debug unit answers on, acting as the PC-side protocol engine in hardware.
- Loads a program from a local program ROM, issues a run or step command, and collects the state dump returned by the target: status, PC, register bank and data memory.
- Sits beside a UART2 instance in board self-test and loopback builds. It is the counterpart of the debug unit: it sends commands and consumes dumps.

Parameters:
NB_DATA, 32, instruction/response word width
N_BITS, 8, UART byte width
NB_ADDR, 8, program ROM address width; max program length 255 instructions
N_REGS, 32, register words in each dump
N_MEM_WORDS, 32, data-memory words in each dump
NB_INDEX, 7, width of response word index
NB_TIMEOUT, 24, watchdog counter width
TIMEOUT_CYCLES, 1000000, max idle cycles waiting on tx_done or rx_done
NB_STATE, 10, one-hot state vector width

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  one-cycle pulse; begin session (accepted in IDLE, DONE, ERROR)
i_step_mode  in  1  sampled at i_start: 0 = continuous (cmd 0x02), 1 = step (cmd 0x03)
i_prog_len  in  NB_ADDR  instruction count, sampled at i_start
o_prog_addr  out  NB_ADDR  ROM address; i_prog_data valid one cycle later
i_prog_data  in  NB_DATA  ROM instruction
o_tx_data  out  N_BITS  byte to UART, held until i_tx_done
o_tx_start  out  1  one-cycle pulse per byte
i_tx_done  in  1  UART transmit-done tick
i_rx_data  in  N_BITS  received byte
i_rx_done  in  1  UART receive-done tick
o_resp_word  out  NB_DATA  assembled response word
o_resp_index  out  NB_INDEX  0 = PC, 1..N_REGS = registers, then memory words
o_resp_valid  out  1  one-cycle pulse per assembled word
o_status  out  N_BITS  last status byte received
o_busy  out  1  high outside IDLE/DONE/ERROR
o_done  out  1  high in DONE
o_error  out  1  high in ERROR
o_state  out  NB_STATE  one-hot current state

Behaviour:
- Reset values: all outputs 0 except o_state = IDLE one-hot (bit 0). Reset mid-operation aborts immediately; no further tx_start pulses.
- States, one-hot in bit order: IDLE, SEND_LOAD, SEND_LEN, FETCH, SEND_INSTR, SEND_EXEC, RX_STATUS, RX_WORD, DONE, ERROR.
- Byte transmit rule: in any SEND state, assert o_tx_start for 1 cycle with o_tx_data valid. Then wait for i_tx_done, and issue the next byte no earlier than the cycle after it.
- IDLE/DONE/ERROR + i_start -> SEND_LOAD. Latch mode and length; clear o_done, o_error, the instruction counter and the word index.
- i_start while busy is ignored.
- SEND_LOAD: sends 0x01. SEND_LEN: sends i_prog_len.
  - If length = 0 -> SEND_EXEC.
  - Otherwise -> FETCH.
- FETCH: drive o_prog_addr = counter; capture i_prog_data the next cycle (2 cycles in FETCH) -> SEND_INSTR.
- SEND_INSTR: 4 bytes, MSB first. Then increment the counter.
  - If counter = len -> SEND_EXEC.
  - Otherwise -> FETCH.
- SEND_EXEC: sends 0x02 (continuous) or 0x03 (step) -> RX_STATUS.
- RX_STATUS: first i_rx_done byte -> o_status.
  - 0x00 (running) or 0xFF (halted) -> RX_WORD, index = 0.
  - Any other value -> ERROR.
- RX_WORD: shift register, word = {word[23:0], byte}, MSB first.
  - On every 4th byte: o_resp_word = word, o_resp_valid pulses in the cycle after the 4th i_rx_done, and the index increments.
  - Frame complete after 1 + N_REGS + N_MEM_WORDS words (65 with defaults).
- End of frame:
  - status 0xFF -> DONE.
  - status 0x00 and step mode -> SEND_EXEC (issue the next 0x03).
  - status 0x00 and continuous mode -> ERROR.
- Watchdog: counter clears on every state change, i_tx_done and i_rx_done. It counts every cycle while waiting on tx_done or rx_done. Reaching TIMEOUT_CYCLES -> ERROR.
- i_rx_done outside RX states is ignored (byte discarded). i_tx_done while not waiting is ignored.
- Simultaneous i_tx_done and i_rx_done: each is handled only if the current state waits on it.
- Index and length arithmetic is unsigned. The index does not wrap within a frame; it resets to 0 at every RX_STATUS entry.

Test Plan:
- Load 2 instructions {0x20010005, 0xFC000000}, continuous mode. Required tx byte sequence: 01 02 20 01 00 05 FC 00 00 00 02. Model replies FF + 65 words → 65 resp_valid pulses, indices 0..64, word0 = PC value sent, o_done = 1.
- Step mode, prog_len = 1. Model replies status 00 + frame, then FF + frame. Required: exactly two 0x03 bytes sent, 130 resp_valid pulses total, DONE.
- prog_len = 0. Required: tx bytes 01 00 02 only; no ROM reads beyond address 0 being driven.
- Model never answers after 0x02. After TIMEOUT_CYCLES (set 1000 in sim), o_error = 1 and o_state = ERROR. Then i_start re-runs the session cleanly.
- Status byte 0x5A → ERROR, no resp_valid pulses. Separately, i_reset asserted mid-SEND_INSTR → next cycle state IDLE, all outputs 0, no further tx_start.
- Noise: an rx_done pulse during SEND_LEN is ignored, and i_start pulsed while busy is ignored. The byte sequence is unchanged from the first scenario.
